// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the hazards forwarding cannot cover:
// load-use stalls, multi-cycle MUL/DIV sequencing, taken-branch flushes, stall statistics.
module pipeline_hazard_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_IF_ID,
    input  logic [4:0]       rs2_IF_ID,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic [4:0]       rd_ID_EX,
    input  logic             MemRead_ID_EX,
    input  logic             mdu_issue_ID,
    input  logic             branch_taken,
    input  logic             stat_clr,
    output logic             stall_PC,
    output logic             stall_IF_ID,
    output logic             bubble_ID_EX,
    output logic             flush_IF_ID,
    output logic             mdu_start,
    output logic             mdu_done,
    output logic             mdu_abort,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int CW = $clog2(MDU_LATENCY);
    localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LATENCY - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {IDLE, MDU_BUSY, MDU_RELEASE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lu;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign lu = MemRead_ID_EX && (rd_ID_EX != 5'd0) &&
                ((use_rs1 && (rd_ID_EX == rs1_IF_ID)) ||
                 (use_rs2 && (rd_ID_EX == rs2_IF_ID)));

    // Outputs are forced low while reset is held, even if inputs are still active.
    always_comb begin
        stall_PC     = 1'b0;
        bubble_ID_EX = 1'b0;
        flush_IF_ID  = 1'b0;
        mdu_start    = 1'b0;
        mdu_done     = 1'b0;
        mdu_abort    = 1'b0;
        busy         = 1'b0;
        if (rst_n) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (branch_taken) begin
                        flush_IF_ID  = 1'b1;
                        bubble_ID_EX = 1'b1;
                    end else if (lu) begin
                        stall_PC     = 1'b1;
                        bubble_ID_EX = 1'b1;
                    end else if (mdu_issue_ID) begin
                        mdu_start    = 1'b1;
                        stall_PC     = 1'b1;
                        bubble_ID_EX = 1'b1;
                    end
                end
                MDU_BUSY: begin
                    if (branch_taken) begin
                        flush_IF_ID  = 1'b1;
                        bubble_ID_EX = 1'b1;
                        mdu_abort    = 1'b1;
                    end else begin
                        stall_PC     = 1'b1;
                        bubble_ID_EX = 1'b1;
                        mdu_done     = (cnt == CNT_LAST);
                    end
                end
                MDU_RELEASE: begin
                    if (branch_taken) begin
                        flush_IF_ID  = 1'b1;
                        bubble_ID_EX = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_IF_ID = stall_PC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A coincident load-use stall defers the MDU issue by one cycle.
                    if (!branch_taken && !lu && mdu_issue_ID) begin
                        state <= MDU_BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                MDU_BUSY: begin
                    if (branch_taken) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= MDU_RELEASE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                MDU_RELEASE: state <= IDLE;
                default:     state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        stall_count <= '0;
        else if (stat_clr) stall_count <= '0;
        else if (stall_PC) stall_count <= sat_inc(stall_count);
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl: default instance plus a CNT_W=4 instance
// sharing the same stimulus to exercise counter saturation.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1_IF_ID = '0, rs2_IF_ID = '0, rd_ID_EX = '0;
    logic       use_rs1 = 1'b0, use_rs2 = 1'b0, MemRead_ID_EX = 1'b0;
    logic       mdu_issue_ID = 1'b0, branch_taken = 1'b0, stat_clr = 1'b0;

    logic        stall_PC, stall_IF_ID, bubble_ID_EX, flush_IF_ID;
    logic        mdu_start, mdu_done, mdu_abort, busy;
    logic [15:0] stall_count;
    logic        s_stall_PC, s_stall_IF_ID, s_bubble_ID_EX, s_flush_IF_ID;
    logic        s_mdu_start, s_mdu_done, s_mdu_abort, s_busy;
    logic [3:0]  s_stall_count;
    logic [7:0]  outs;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .rd_ID_EX(rd_ID_EX),
        .MemRead_ID_EX(MemRead_ID_EX), .mdu_issue_ID(mdu_issue_ID),
        .branch_taken(branch_taken), .stat_clr(stat_clr),
        .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .bubble_ID_EX(bubble_ID_EX),
        .flush_IF_ID(flush_IF_ID), .mdu_start(mdu_start), .mdu_done(mdu_done),
        .mdu_abort(mdu_abort), .busy(busy), .stall_count(stall_count)
    );

    pipeline_hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .rd_ID_EX(rd_ID_EX),
        .MemRead_ID_EX(MemRead_ID_EX), .mdu_issue_ID(mdu_issue_ID),
        .branch_taken(branch_taken), .stat_clr(stat_clr),
        .stall_PC(s_stall_PC), .stall_IF_ID(s_stall_IF_ID), .bubble_ID_EX(s_bubble_ID_EX),
        .flush_IF_ID(s_flush_IF_ID), .mdu_start(s_mdu_start), .mdu_done(s_mdu_done),
        .mdu_abort(s_mdu_abort), .busy(s_busy), .stall_count(s_stall_count)
    );

    assign outs = {stall_PC, stall_IF_ID, bubble_ID_EX, flush_IF_ID,
                   mdu_start, mdu_done, mdu_abort, busy};

    // {stall_PC, stall_IF_ID, bubble_ID_EX, flush_IF_ID, mdu_start, mdu_done, mdu_abort, busy}
    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_LU    = 8'b1110_0000;
    localparam logic [7:0] O_START = 8'b1110_1000;
    localparam logic [7:0] O_BUSY  = 8'b1110_0001;
    localparam logic [7:0] O_DONE  = 8'b1110_0101;
    localparam logic [7:0] O_REL   = 8'b0000_0001;
    localparam logic [7:0] O_FLUSH = 8'b0011_0000;
    localparam logic [7:0] O_ABORT = 8'b0011_0011;
    localparam logic [7:0] O_RELFL = 8'b0011_0001;

    typedef struct {
        string       tag;
        logic [7:0]  outs;
        logic [15:0] c16;
        logic [3:0]  c4;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m16 = '0;
    logic [3:0]  m4  = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                          input logic [4:0] r2, input logic u1, input logic u2,
                          input logic mdu, input logic br, input logic clr);
        MemRead_ID_EX = mr; rd_ID_EX = rd; rs1_IF_ID = r1; rs2_IF_ID = r2;
        use_rs1 = u1; use_rs2 = u2; mdu_issue_ID = mdu; branch_taken = br; stat_clr = clr;
    endtask

    task automatic idle_in();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called just after a rising edge with inputs already driven for this cycle.
    task automatic step(input string tag, input logic [7:0] e);
        exp_t x;
        if (!rst_n) begin
            m16 = '0;
            m4  = '0;
        end
        x.tag = tag; x.outs = e; x.c16 = m16; x.c4 = m4;
        sb.push_back(x);
        @(negedge clk);
        x = sb.pop_front();
        checks++;
        assert (outs === x.outs) else begin
            errors++;
            $error("FAIL %s outputs: observed %b expected %b", x.tag, outs, x.outs);
        end
        checks++;
        assert (stall_count === x.c16) else begin
            errors++;
            $error("FAIL %s stall_count: observed %0d expected %0d", x.tag, stall_count, x.c16);
        end
        checks++;
        assert (s_stall_count === x.c4) else begin
            errors++;
            $error("FAIL %s stall_count_w4: observed %0d expected %0d", x.tag, s_stall_count, x.c4);
        end
        if (rst_n) begin
            if (stat_clr) begin
                m16 = '0;
                m4  = '0;
            end else if (e[7]) begin
                if (m16 != 16'hFFFF) m16 = m16 + 16'd1;
                if (m4 != 4'hF) m4 = m4 + 4'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle_in();
        @(posedge clk); #1;
        step("reset0", O_NONE);
        step("reset1", O_NONE);
        rst_n = 1'b1;
        step("idle", O_NONE);

        // Load-use
        set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step("lu_rs1", O_LU);
        idle_in();                                                     step("lu_after", O_NONE);
        set_in(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step("lu_rs2", O_LU);
        set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step("lu_nouse", O_NONE);
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step("lu_rd0", O_NONE);
        set_in(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step("lu_noload", O_NONE);

        // MDU op with issue held through the release cycle
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("mdu_t0", O_START);
        step("mdu_t1", O_BUSY);
        step("mdu_t2", O_BUSY);
        step("mdu_t3", O_DONE);
        step("mdu_t4", O_REL);
        idle_in();
        step("mdu_t5", O_NONE);

        // Load-use coincident with MDU issue
        set_in(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step("lumdu_t0", O_LU);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step("lumdu_t1", O_START);
        step("lumdu_t2", O_BUSY);
        step("lumdu_t3", O_BUSY);
        step("lumdu_t4", O_DONE);
        step("lumdu_t5", O_REL);
        idle_in();
        step("lumdu_t6", O_NONE);

        // Branch in IDLE beats load-use and MDU issue
        set_in(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); step("br_idle", O_FLUSH);
        idle_in();                                                     step("br_idle_after", O_NONE);

        // Branch in first busy cycle aborts the MDU op
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step("abort_t0", O_START);
        branch_taken = 1'b1;                                           step("abort_t1", O_ABORT);
        idle_in();                                                     step("abort_t2", O_NONE);

        // Branch during release
        mdu_issue_ID = 1'b1;
        step("brrel_t0", O_START);
        step("brrel_t1", O_BUSY);
        step("brrel_t2", O_BUSY);
        step("brrel_t3", O_DONE);
        branch_taken = 1'b1;
        step("brrel_t4", O_RELFL);
        idle_in();
        step("brrel_t5", O_NONE);

        // Saturation and clear
        stat_clr = 1'b1;
        step("clr", O_NONE);
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("sat", O_LU);
        stat_clr = 1'b1;
        step("clr_stall", O_LU);
        idle_in();
        step("clr_after", O_NONE);

        // Reset mid-MDU with issue still asserted
        mdu_issue_ID = 1'b1;
        step("rstmdu_t0", O_START);
        step("rstmdu_t1", O_BUSY);
        rst_n = 1'b0;
        step("rstmdu_rst", O_NONE);
        mdu_issue_ID = 1'b0;
        rst_n = 1'b1;
        step("rstmdu_idle", O_NONE);
        step("rstmdu_idle2", O_NONE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
